// File: rtl/core_pkg.sv
// Shared core definitions: reset vector, word widths and the fetch FSM encoding.
// Imported by the fetch stage and its FIFO.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FIFO entry: {pc[31:2], instruction[31:0]}
    localparam int PC_W = 30;
    localparam int ENTRY_W = PC_W + XLEN;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and registered head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO accepts a push only when the head leaves in the same cycle.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, redirect handling and a small FIFO feeding decode.
// Define INSTR_FETCH_PERF_EN to build the fetch/stall performance counters.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_en_i,
    output logic [31:2]     cache_addr_o,
    input  logic [XLEN-1:0] cache_data_i,
    input  logic            redirect_i,
    input  logic [31:2]     redirect_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_instr_o,
    output logic [31:2]     dec_pc_o,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_stall_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PC_W-1:0]    pc_q, pc_d;
    fetch_state_e       state_q, state_d;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               full, push, pop;

    assign full = (count == FULL_CNT);
    assign pop  = dec_valid_o & dec_ready_i;
    assign push = fetch_en_i & ~redirect_i & (~full | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (push) begin
            pc_d = pc_q + 30'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = fetch_en_i ? ST_RUN : ST_HOLD;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!fetch_en_i) begin
                        state_d = ST_HOLD;
                    end else if (full && !pop) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: if (pop) state_d = ST_RUN;
                ST_HOLD:  if (fetch_en_i) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC[31:2];
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, cache_data_i}),
        .rdata_o (head),
        .count_o (count)
    );

    assign cache_addr_o = pc_q;
    assign dec_valid_o  = (count != '0);
    assign dec_pc_o     = head[ENTRY_W-1:XLEN];
    assign dec_instr_o  = head[XLEN-1:0];

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall_cyc;

    assign stall_cyc = fetch_en_i & ~redirect_i & full & ~pop;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, push};
        perf_stall_d = perf_stall_q + {31'd0, stall_cyc};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_fetch_o = 32'h0;
    assign perf_stall_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked
// against a queue model of the in-flight instruction stream.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        fetch_en_i;
    logic [31:2] cache_addr_o;
    logic [31:0] cache_data_i;
    logic        redirect_i;
    logic [31:2] redirect_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [31:2] dec_pc_o;
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;

    always #5 clk = ~clk;

    // Cache model: the word at address A is A<<2.
    assign cache_data_i = {cache_addr_o, 2'b00};

    instr_fetch #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .fetch_en_i    (fetch_en_i),
        .cache_addr_o  (cache_addr_o),
        .cache_data_i  (cache_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
    );

    logic [29:0] m_pc;
    logic [29:0] q_pc[$];
    int unsigned n_push;
    int unsigned n_stall;
    bit          m_zero_head;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        m_pc        = 30'h40;
        n_push      = 0;
        n_stall     = 0;
        m_zero_head = 1'b1;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cyc(input logic rst, input logic fe, input logic rdy,
                       input logic rd, input logic [29:0] tgt);
        bit pop;
        bit push;
        rst_ni        = rst;
        fetch_en_i    = fe;
        dec_ready_i   = rdy;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        @(negedge clk);
        check("cache_addr", 32'(cache_addr_o), 32'(m_pc));
        check("dec_valid", 32'(dec_valid_o), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            check("dec_pc", 32'(dec_pc_o), 32'(q_pc[0]));
            check("dec_instr", dec_instr_o, {q_pc[0], 2'b00});
        end else if (m_zero_head) begin
            check("dec_pc_rst", 32'(dec_pc_o), 32'h0);
            check("dec_instr_rst", dec_instr_o, 32'h0);
        end
`ifdef INSTR_FETCH_PERF_EN
        check("perf_fetch", perf_fetch_o, n_push);
        check("perf_stall", perf_stall_o, n_stall);
`else
        check("perf_fetch", perf_fetch_o, 32'h0);
        check("perf_stall", perf_stall_o, 32'h0);
`endif
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            pop  = (q_pc.size() != 0) && rdy;
            push = fe && !rd && ((q_pc.size() < DEPTH) || pop);
            if (fe && !rd && q_pc.size() == DEPTH && !pop) n_stall++;
            if (push) n_push++;
            if (rd) begin
                q_pc.delete();
                m_pc = tgt;
            end else begin
                if (pop) void'(q_pc.pop_front());
                if (push) begin
                    q_pc.push_back(m_pc);
                    m_pc        = m_pc + 30'd1;
                    m_zero_head = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic        r_rst, r_fe, r_rdy, r_rd;
        logic [29:0] r_tgt;

        rst_ni        = 1'b0;
        fetch_en_i    = 1'b0;
        dec_ready_i   = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset release: 0x40, 0x41, ... back to back
        repeat (6) cyc(1, 1, 1, 0, 30'h0);

        // Empty the FIFO, then hold decode off for 5 cycles
        cyc(1, 1, 1, 1, 30'h80);
        repeat (5) cyc(1, 1, 0, 0, 30'h0);
        repeat (4) cyc(1, 1, 1, 0, 30'h0);

        // Redirect while full
        repeat (3) cyc(1, 1, 0, 0, 30'h0);
        cyc(1, 1, 0, 1, 30'h200);
        repeat (4) cyc(1, 1, 1, 0, 30'h0);

        // Redirect with fetch disabled, then re-enable
        cyc(1, 0, 1, 1, 30'h300);
        repeat (2) cyc(1, 0, 1, 0, 30'h0);
        repeat (3) cyc(1, 1, 1, 0, 30'h0);

        // PC wrap at the top of the address space
        cyc(1, 1, 1, 1, 30'h3FFF_FFFF);
        repeat (4) cyc(1, 1, 1, 0, 30'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r_rst = ($urandom_range(0, 99) != 0);
            r_fe  = ($urandom_range(0, 7) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_tgt = 30'($urandom);
            cyc(r_rst, r_fe, r_rdy, r_rd, r_tgt);
        end

        // Reset with two valid entries
        cyc(1, 1, 1, 1, 30'h500);
        repeat (3) cyc(1, 1, 0, 0, 30'h0);
        cyc(0, 1, 0, 0, 30'h0);
        repeat (3) cyc(1, 1, 1, 0, 30'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
